mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit. It consumes the MDU control bundle that the decoder produces from the instruction word: start, op, and the HI/LO write enables.
- Computes mult/multu/div/divu over a fixed multi-cycle latency. It also services mthi/mtlo writes.
- Holds the architectural HI/LO registers, which feed the E-stage result mux for mfhi/mflo.
- Drives busy so the hazard unit can stall MD-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  launch operation selected by op (decoder isMd)
- op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=madd, 5=maddu (4/5 only with the optional feature)
- hi_write  in  1  mthi: HI <= a
- lo_write  in  1  mtlo: LO <= a
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- busy  out  1  operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset: reset low at a clock edge forces hi=0, lo=0, busy=0, state=IDLE, counter=0. Reset mid-operation aborts the operation and discards its result.

States: IDLE, RUN.

IDLE:
- start=1 with a legal op: latch op, a and b, and compute the pending {HI,LO} result. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- If start=1 and the launch cycle is t, busy=1 from cycle t+1 through t+N, where N is the op's cycle count.
- start=1 with an illegal op (6, 7, or 4/5 with the feature disabled): no effect, stay IDLE.

RUN:
- Decrement the counter each cycle.
- When the counter reaches 1, commit the pending result to hi/lo on that edge and go to IDLE.
- New hi/lo values are visible from cycle t+N+1, in the same cycle busy drops.

Arithmetic:
- mult: signed 32x32 to 64; multu: unsigned. HI = product[63:32], LO = product[31:0].
- div: signed; quotient truncates toward zero, remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- divu: unsigned.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (b=0, div or divu): full latency and busy behaviour, but HI/LO stay unchanged at commit.

Priority and simultaneous events:
- hi_write/lo_write take effect only in IDLE with start=0, on that edge; the new value is visible the next cycle.
- start together with hi_write/lo_write: start wins and the writes are dropped.
- hi_write and lo_write together: both are written from a.
- In RUN, start, hi_write and lo_write are ignored; the hazard unit guarantees none arrive.
- The result is never partially visible: hi/lo hold their old values throughout RUN.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 4 (madd, signed) and op 5 (maddu, unsigned) are legal. Commit value is {HI,LO} + a*b, modulo 2^64, using the {HI,LO} value sampled at launch; latency is MULT_CYCLES.
- Not defined: ops 4 and 5 are illegal and ignored per the IDLE rule; the datapath contains no accumulate adder.

Decomposition:
- Package mdu_pkg: op encodings (MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MADD=4, MDU_MADDU=5), state encoding, default cycle constants.
- Sub-module mdu_arith: combinational. Takes op, a, b and the current {HI,LO}; outputs the 64-bit pending result and a div0 flag.
- mdu_unit owns the FSM, counter, HI/LO and the pending-result registers.

Test Plan:
- Reset, then mult with a=0xFFFFFFFF (-1), b=2 at cycle t: busy high t+1..t+5; from t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with a=0xFFFFFFFF, b=2: hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div a=-7 (0xFFFFFFF9), b=2: busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Separately, divu by b=0 after mthi 0x1234: hi stays 0x1234, lo stays unchanged.
- lo_write a=0xDEAD in IDLE: lo=0xDEAD next cycle. start=1 with hi_write=1 in the same cycle: hi is not written, the op runs.
- During RUN, assert start, hi_write and lo_write: hi/lo unchanged until commit and the busy length is unaffected. Drive reset low at busy cycle 3: busy=0, hi=lo=0 next cycle, and no later commit occurs.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu a=1, b=1 gives hi=1, lo=0. Without the macro, the same op leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu accumulate ops).
package mdu_pkg;

  // Operation encodings carried on the op port from the decoder.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5
  } mdu_op_e;

  // Controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Default busy lengths for the multiplier and divider paths.
  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // True for encodings that launch an operation in this build.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: legal = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    legal = 1'b1;
`endif
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True for the divider ops, which use the longer latency.
  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: produces the 64-bit {HI,LO} value an
// operation will commit, plus a flag marking divide-by-zero.
// Optional feature macro: MDU_MADD_EN (adds the {HI,LO} accumulate adder).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [63:0] i_hilo,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_product;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Operand conditioning, one shared multiplier and one shared magnitude divider.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    w_signed  = (i_op == MDU_MULT) || (i_op == MDU_DIV) || (i_op == MDU_MADD);
    w_a_ext   = {{32{w_signed & i_a[31]}}, i_a};
    w_b_ext   = {{32{w_signed & i_b[31]}}, i_b};
    // The low 64 bits of the sign/zero-extended product are exact for both signednesses.
    w_product = w_a_ext * w_b_ext;

    // Signed division runs on magnitudes; 0x80000000 as a magnitude is exact
    // when read unsigned, so the -2^31 / -1 overflow case falls out naturally.
    w_a_neg  = w_signed & i_a[31];
    w_b_neg  = w_signed & i_b[31];
    w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
    w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;
    w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  end

  // Select the committed value for the requested op.
  always_comb begin
    o_result = 64'd0;
    o_div0   = 1'b0;
    case (i_op)
      MDU_MULT, MDU_MULTU: o_result = w_product;
      MDU_DIV, MDU_DIVU: begin
        o_result = {w_rem, w_quot};
        o_div0   = (i_b == 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: o_result = i_hilo + w_product;
`endif
      default: o_result = 64'd0;
    endcase
  end

`ifndef MDU_MADD_EN
  // Without accumulate ops the current {HI,LO} has no consumer here.
  logic w_unused_hilo;
  assign w_unused_hilo = ^i_hilo;
`endif

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: fixed-latency mult/multu/div/divu,
// mthi/mtlo servicing, architectural HI/LO and a busy flag for the hazard unit.
// Optional feature macro: MDU_MADD_EN (madd/maddu accumulate into {HI,LO}).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] L_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] L_DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_pend;
  logic        r_div0;

  logic        w_launch;
  logic [63:0] w_result;
  logic        w_div0;

  assign w_launch = (r_state == IDLE) && start && op_is_legal(op);

  mdu_arith u_arith (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_hilo   ({r_hi, r_lo}),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  // Controller: launch, countdown, commit, and mthi/mtlo writes while idle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // start wins over mthi/mtlo; an illegal op is simply ignored.
            if (op_is_legal(op)) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_cnt   <= op_is_div(op) ? L_DIV_CNT : L_MULT_CNT;
            end
          end else begin
            if (hi_write) r_hi <= a;
            if (lo_write) r_lo <= a;
          end
        end
        RUN: begin
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            // Divide-by-zero runs the full latency but leaves HI/LO untouched.
            if (!r_div0) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Capture the pending result at launch; it is only read back in RUN.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath holding registers need no reset; the controller never commits them without a fresh launch.
    if (w_launch) begin
      r_pend <= w_result;
      r_div0 <= w_div0;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
